// File: rtl/gray_sequence_checker.sv
// gray_sequence_checker
//
// Receive-side checker for a 4-bit Gray-coded counter bus. On every
// qualified cycle it samples the code and decodes it to binary. It then
// checks that the new value is exactly one more (mod 16) than the previous
// sample. The block keeps a HUNT/LOCKED state, a per-step error pulse and a
// saturating error count.
//
// Parameters
//   LOCK_N    consecutive good steps needed to enter LOCKED (1..15)
//   UNLOCK_N  consecutive bad steps needed to drop back to HUNT (1..15)
//   CNT_W     width of err_cnt (>= 2)
//
// Ports
//   clk        rising-edge clock
//   clr        asynchronous active-low reset
//   valid      code is sampled on this cycle
//   code       Gray-coded count value
//   bin        registered binary decode of the last sampled code
//   bin_valid  registered copy of valid
//   locked     high while the FSM is in LOCKED
//   step_err   one-cycle pulse for each bad step
//   err_cnt    saturating count of bad steps
//   dbg_state  {run[3:0], fsm state}; observation only
//
// Handshake: valid-only, with no backpressure. A sample is consumed on
// every rising edge where valid=1 and clr=1. Throughput is one per clock,
// and valid may toggle every cycle.
module gray_sequence_checker #(
  parameter int LOCK_N   = 2,
  parameter int UNLOCK_N = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             valid,
  input  logic [3:0]       code,
  output logic [3:0]       bin,
  output logic             bin_valid,
  output logic             locked,
  output logic             step_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [4:0]       dbg_state
);

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  localparam logic [3:0]       LOCK_THR   = 4'(LOCK_N);
  localparam logic [3:0]       UNLOCK_THR = 4'(UNLOCK_N);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t     state, state_nxt;
  logic [3:0] run, run_nxt, run_inc;
  logic [3:0] prev;
  logic       have_prev;
  logic [3:0] dec;
  logic       good, bad;

  // Gray to binary conversion: each bit is the XOR of every Gray bit at or above it.
  always_comb begin
    dec[3] = code[3];
    dec[2] = dec[3] ^ code[2];
    dec[1] = dec[2] ^ code[1];
    dec[0] = dec[1] ^ code[0];
  end

  // Next-state logic. The first sample after reset only primes prev, so it
  // is never classified as good or bad.
  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    good      = 1'b0;
    bad       = 1'b0;
    run_inc   = run + 4'd1;
    if (valid && have_prev) begin
      // 4-bit addition wraps, so the step 15 -> 0 counts as good.
      if (dec == 4'(prev + 4'd1)) good = 1'b1;
      else                        bad  = 1'b1;
    end
    case (state)
      S_HUNT: begin
        if (good) begin
          if (run_inc == LOCK_THR) begin
            state_nxt = S_LOCKED;
            run_nxt   = 4'd0;
          end else begin
            run_nxt = run_inc;
          end
        end else if (bad) begin
          run_nxt = 4'd0;
        end
      end
      S_LOCKED: begin
        if (bad) begin
          if (run_inc == UNLOCK_THR) begin
            state_nxt = S_HUNT;
            run_nxt   = 4'd0;
          end else begin
            run_nxt = run_inc;
          end
        end else if (good) begin
          run_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = S_HUNT;
        run_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_HUNT;
      run       <= 4'd0;
      prev      <= 4'd0;
      have_prev <= 1'b0;
      bin       <= 4'd0;
      bin_valid <= 1'b0;
      step_err  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      run       <= run_nxt;
      bin_valid <= valid;
      step_err  <= bad;
      if (valid) begin
        prev      <= dec;
        have_prev <= 1'b1;
        bin       <= dec;
      end
      if (bad && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + 1'b1;
    end
  end

  assign locked    = (state == S_LOCKED);
  assign dbg_state = {run, state};

endmodule

// File: tb/tb_gray_sequence_checker.sv
module tb_gray_sequence_checker;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] code = 4'd0;

  logic [3:0] bin, bin_s;
  logic       bin_valid, bin_valid_s;
  logic       locked, locked_s;
  logic       step_err, step_err_s;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt_s;
  logic [4:0] dbg, dbg_s;

  int n_total = 0;
  int n_bad   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  gray_sequence_checker #(.LOCK_N(2), .UNLOCK_N(2), .CNT_W(8)) u_dut (
    .clk(clk), .clr(clr), .valid(valid), .code(code),
    .bin(bin), .bin_valid(bin_valid), .locked(locked),
    .step_err(step_err), .err_cnt(err_cnt), .dbg_state(dbg)
  );

  gray_sequence_checker #(.LOCK_N(2), .UNLOCK_N(2), .CNT_W(2)) u_sat (
    .clk(clk), .clr(clr), .valid(valid), .code(code),
    .bin(bin_s), .bin_valid(bin_valid_s), .locked(locked_s),
    .step_err(step_err_s), .err_cnt(err_cnt_s), .dbg_state(dbg_s)
  );

  // vector table
  typedef struct {
    logic       v;
    logic [3:0] val;
    logic [3:0] e_bin;
    logic       e_bv;
    logic       e_lock;
    logic       e_se;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [3:0] to_gray(input logic [3:0] n);
    return n ^ (n >> 1);
  endfunction

  function automatic void add(input logic v, input logic [3:0] val, input logic [3:0] e_bin,
                              input logic e_bv, input logic e_lock, input logic e_se,
                              input logic [7:0] e_cnt);
    vec_t t;
    t.v = v; t.val = val; t.e_bin = e_bin; t.e_bv = e_bv;
    t.e_lock = e_lock; t.e_se = e_se; t.e_cnt = e_cnt;
    vecs.push_back(t);
  endfunction

  // scoreboard compare
  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] e_bin, input logic e_bv,
                         input logic e_lock, input logic e_se, input logic [7:0] e_cnt);
    chk({tag, ".bin"},       int'(bin),       int'(e_bin));
    chk({tag, ".bin_valid"}, int'(bin_valid), int'(e_bv));
    chk({tag, ".locked"},    int'(locked),    int'(e_lock));
    chk({tag, ".step_err"},  int'(step_err),  int'(e_se));
    chk({tag, ".err_cnt"},   int'(err_cnt),   int'(e_cnt));
  endtask

  // driver: present inputs mid-cycle, take one edge, settle past it
  task automatic step(input logic v, input logic [3:0] val);
    valid = v;
    code  = to_gray(val);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b0;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
  endtask

  initial begin
    // clean run 0..15,0..3; lock after 3rd sample
    for (int i = 0; i < 20; i++) begin
      add(1'b1, 4'(i % 16), 4'(i % 16), 1'b1, (i >= 2), 1'b0, 8'd0);
    end
    // single skip while locked (5 -> 7), then 8 is good
    add(1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b1, 4'd7, 4'd7, 1'b1, 1'b1, 1'b1, 8'd1);
    add(1'b1, 4'd8, 4'd8, 1'b1, 1'b1, 1'b0, 8'd1);
    // one bad after 8 keeps lock (run was cleared by 8)
    add(1'b1, 4'd3, 4'd3, 1'b1, 1'b1, 1'b1, 8'd2);
    add(1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b0, 8'd2);
    add(1'b1, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 8'd2);
    // loss: 5 -> 9 -> 2, then reacquire with 3,4
    add(1'b1, 4'd9, 4'd9, 1'b1, 1'b1, 1'b1, 8'd3);
    add(1'b1, 4'd2, 4'd2, 1'b1, 1'b0, 1'b1, 8'd4);
    add(1'b1, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0, 8'd4);
    add(1'b1, 4'd4, 4'd4, 1'b1, 1'b1, 1'b0, 8'd4);
    // gaps: bin holds, bin_valid follows valid, no errors
    add(1'b0, 4'd15, 4'd4, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b1, 4'd5,  4'd5, 1'b1, 1'b1, 1'b0, 8'd4);
    add(1'b0, 4'd0,  4'd5, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b1, 4'd6,  4'd6, 1'b1, 1'b1, 1'b0, 8'd4);
    add(1'b0, 4'd1,  4'd6, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b0, 4'd2,  4'd6, 1'b0, 1'b1, 1'b0, 8'd4);
    add(1'b1, 4'd7,  4'd7, 1'b1, 1'b1, 1'b0, 8'd4);

    // reset state
    clr = 1'b0;
    #1;
    chk_all("por", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    do_reset();
    chk_all("after_rst", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);

    // table
    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].val);
      chk_all($sformatf("vec%0d", i), vecs[i].e_bin, vecs[i].e_bv, vecs[i].e_lock,
              vecs[i].e_se, vecs[i].e_cnt);
    end

    // async reset while locked with err_cnt=4
    chk("pre_arst.locked", int'(locked), 1);
    #2;
    clr = 1'b0;
    #1;
    chk_all("arst_now", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 4'd5);
    chk_all("arst_hold", 4'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    clr = 1'b1;
    // first sample after release is never an error; then a repeat is bad
    step(1'b1, 4'd3);
    chk_all("first_smp", 4'd3, 1'b1, 1'b0, 1'b0, 8'd0);
    step(1'b1, 4'd3);
    chk_all("repeat", 4'd3, 1'b1, 1'b0, 1'b1, 8'd1);
    step(1'b1, 4'd4);
    chk_all("after_rep", 4'd4, 1'b1, 1'b0, 1'b0, 8'd1);

    // saturation with CNT_W=2: six back-to-back bad steps
    do_reset();
    step(1'b1, 4'd0);
    chk("sat_first.cnt", int'(err_cnt_s), 0);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, 4'd0);
      chk($sformatf("sat%0d.cnt", k), int'(err_cnt_s), (k < 3) ? k : 3);
      chk($sformatf("sat%0d.step_err", k), int'(step_err_s), 1);
      chk($sformatf("sat%0d.cnt8", k), int'(err_cnt), k);
    end
    step(1'b0, 4'd0);
    chk("sat_idle.step_err", int'(step_err_s), 0);
    chk("sat_idle.cnt", int'(err_cnt_s), 3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
